// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: circular FIFO plus a start-pulse FSM with busy timeout.
// Optional sticky overflow flag: define UART_TXQ_OVERFLOW_STICKY_EN.
module uart_tx_queue #(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     uart_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic          full_w, empty_w, push, pop;

  assign full_w  = (count_q == FULL_LEVEL);
  assign empty_w = (count_q == '0);
  // The LOAD cycle frees a slot, so a write landing in it is accepted even when full.
  assign pop     = (state_q == LOAD);
  assign push    = wr_en && (!full_w || pop);

  // NOTE: every signal assigned in always_comb gets a default first; a path that
  // leaves one unassigned infers a latch.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + LW'(push) - LW'(pop);
    tx_data_d = pop  ? mem[rd_ptr_q] : tx_data_q;
    state_d   = state_q;
    tmo_d     = '0;
    case (state_q)
      IDLE:      if (!empty_w && !uart_busy) state_d = LOAD;
      LOAD:      state_d = SEND;
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_busy)              state_d = WAIT_DONE;
        else if (tmo_q == TMO_LAST) state_d = IDLE;
        else                        tmo_d   = tmo_q + 1'b1;
      end
      WAIT_DONE: if (!uart_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    tx_send_d = (state_d == SEND);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      tmo_q     <= '0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers alone
  // define which entries are valid, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

`ifdef UART_TXQ_OVERFLOW_STICKY_EN
  logic overflow_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                    overflow_q <= 1'b0;
    else if (wr_en && !push)       overflow_q <= 1'b1;
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign full    = full_w;
  assign empty   = empty_w;
  assign level   = count_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus randomized traffic
// scored against a byte-queue model with a simple reactive UART.
module tb_uart_tx_queue;

  localparam int DEPTH        = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int LW           = $clog2(DEPTH) + 1;
`ifdef UART_TXQ_OVERFLOW_STICKY_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          uart_busy;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data),
    .uart_busy(uart_busy), .tx_data(tx_data), .tx_send(tx_send),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] expq[$];
  int         pulse_cycs[$];
  int         cyc            = 0;
  int         last_pulse_cyc = -100;
  bit         ovf_exp        = 1'b0;
  bit         last_pulse     = 1'b0;
  bit         hold_busy      = 1'b0;
  bit         rand_mode      = 1'b0;
  int         busy_len       = 2;
  int         busy_cnt       = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // One clock: drive the write for the coming edge, then score the outputs at the falling edge.
  task automatic step(input logic we, input logic [7:0] wd);
    bit pulse;
    bit acc;
    wr_en   = we;
    wr_data = wd;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    cyc++;
    pulse      = tx_send;
    last_pulse = pulse;
    acc        = we && (expq.size() < DEPTH || (pulse && expq.size() > 0));
    if (pulse) begin
      pulse_cycs.push_back(cyc);
      check("busy_at_send", uart_busy, 1'b0);
      if (expq.size() == 0) check("spurious_send", 1, 0);
      else                  check("tx_data", tx_data, expq.pop_front());
      if (last_pulse_cyc >= 0)
        check("send_gap_min", (cyc - last_pulse_cyc < 5) ? cyc - last_pulse_cyc : 5, 5);
      last_pulse_cyc = cyc;
    end
    if (we) begin
      if (acc) expq.push_back(wd);
      else     ovf_exp = OVF_EN;
    end
    check("level", level, expq.size());
    check("full",  full,  expq.size() == DEPTH);
    check("empty", empty, expq.size() == 0);
    check("overflow", overflow, ovf_exp);
    // UART model: busy is raised right after each start pulse for busy_len edges (0 = never).
    if (hold_busy) uart_busy = 1'b1;
    else if (pulse) begin
      if (rand_mode) busy_len = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 8));
      busy_cnt  = busy_len;
      uart_busy = (busy_len > 0);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      uart_busy = (busy_cnt != 0);
    end else uart_busy = 1'b0;
  endtask

  task automatic do_reset(input bit keep_uart);
    #2 n_rst = 1'b0;
    #1;
    check("rst_level",    level,    0);
    check("rst_empty",    empty,    1);
    check("rst_full",     full,     0);
    check("rst_tx_data",  tx_data,  8'h00);
    check("rst_tx_send",  tx_send,  0);
    check("rst_overflow", overflow, 0);
    expq.delete();
    ovf_exp        = 1'b0;
    last_pulse_cyc = -100;
    if (!keep_uart) begin
      hold_busy = 1'b0;
      rand_mode = 1'b0;
      busy_cnt  = 0;
      uart_busy = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expq.size() == 0) break;
      step(1'b0, 8'h00);
    end
    repeat (4) step(1'b0, 8'h00);
    check("drain_left", expq.size(), 0);
  endtask

  initial begin
    int p0;
    int wcyc;
    n_rst     = 1'b1;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    uart_busy = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // single byte: pulse two edges after the write edge
    busy_len = 3;
    p0 = pulse_cycs.size();
    step(1'b1, 8'h41);
    wcyc = cyc;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("latency", last_pulse_cyc, wcyc + 2);
    drain(50);
    check("single_pulses", pulse_cycs.size() - p0, 1);

    // ordering with a long busy period after every pulse
    do_reset(1'b0);
    busy_len = 20;
    p0 = pulse_cycs.size();
    step(1'b1, 8'h10);
    step(1'b1, 8'h20);
    step(1'b1, 8'h30);
    drain(200);
    check("order_pulses", pulse_cycs.size() - p0, 3);

    // full and overflow while the UART is held busy
    do_reset(1'b0);
    hold_busy = 1'b1;
    uart_busy = 1'b1;
    p0 = pulse_cycs.size();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(i));
      if (i == 7) check("full_after_8", full, 1);
    end
    check("ovf_flag", overflow, OVF_EN);
    check("level_at_full", level, DEPTH);
    check("no_send_while_busy", pulse_cycs.size() - p0, 0);
    hold_busy = 1'b0;
    uart_busy = 1'b0;
    busy_len  = 2;
    drain(200);
    check("full_pulses", pulse_cycs.size() - p0, 8);

    // push into a full queue during the LOAD cycle
    do_reset(1'b0);
    hold_busy = 1'b1;
    uart_busy = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h50 + 8'(i));
    hold_busy = 1'b0;
    uart_busy = 1'b0;
    busy_len  = 2;
    p0 = pulse_cycs.size();
    step(1'b0, 8'h00);
    step(1'b1, 8'hAA);
    check("simul_send",  last_pulse, 1);
    check("simul_level", level, 8);
    check("simul_ovf",   overflow, 0);
    drain(200);
    check("simul_pulses", pulse_cycs.size() - p0, 9);

    // UART never answers: second pulse follows the busy timeout
    do_reset(1'b0);
    busy_len = 0;
    p0 = pulse_cycs.size();
    step(1'b1, 8'hC1);
    step(1'b1, 8'hC2);
    drain(60);
    check("tmo_pulses", pulse_cycs.size() - p0, 2);
    if (pulse_cycs.size() - p0 == 2)
      check("tmo_gap", pulse_cycs[p0 + 1] - pulse_cycs[p0], BUSY_TIMEOUT + 3);

    // reset while waiting for the UART to finish, three bytes still queued
    do_reset(1'b0);
    busy_len = 10;
    p0 = pulse_cycs.size();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h61 + 8'(i));
    repeat (3) step(1'b0, 8'h00);
    check("pre_rst_level", level, 3);
    check("pre_rst_pulses", pulse_cycs.size() - p0, 1);
    do_reset(1'b1);
    p0 = pulse_cycs.size();
    repeat (30) step(1'b0, 8'h00);
    check("post_rst_quiet", pulse_cycs.size() - p0, 0);
    step(1'b1, 8'h77);
    drain(60);
    check("post_rst_pulses", pulse_cycs.size() - p0, 1);

    // randomized traffic against the model
    do_reset(1'b0);
    rand_mode = 1'b1;
    busy_len  = 3;
    for (int i = 0; i < 1500; i++) begin
      logic we;
      we = ($urandom_range(0, 99) < 30);
      step(we, 8'($urandom));
    end
    drain(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
